fdiv_arbiter: RTL
=================

// Module: fdiv_arbiter
// PURPOSE
//  Shares one combinational fdiv instance among NREQ requesters (FPU issue ports).
//  - Round-robin arbiter chooses the next requester.
//  - Operands are registered and held stable on the fdiv inputs for DIV_CYCLES cycles.
//    The fdiv path is constrained as a DIV_CYCLES multicycle path.
//  - Result and overflow flag are captured and returned to the owner with a valid/ready handshake.
//  - One division is in flight at a time; the fdiv instance sits outside this block.
// PARAMETERS
//  NREQ        4   number of requesters, 2..8
//  DIV_CYCLES  2   cycles operands are held before y/ovf are sampled, >=1
// PORTS
//  clk        in   1        clock; single clock domain
//  rstn       in   1        asynchronous active-low reset
//  req_valid  in   NREQ     per-requester request valid
//  req_ready  out  NREQ     one-hot grant; the handshake completes when req_valid[i]&req_ready[i]
//  req_x1     in   32*NREQ  dividend, slice i = [32*i+31:32*i]
//  req_x2     in   32*NREQ  divisor, same packing
//  resp_valid out  NREQ     one-hot; high for the owner of the finished op
//  resp_ready in   NREQ     per-requester response accept
//  resp_y     out  32       quotient (shared bus; valid only when resp_valid!=0)
//  resp_ovf   out  1        overflow flag from fdiv
//  div_x1     out  32       to fdiv x1
//  div_x2     out  32       to fdiv x2
//  div_y      in   32       from fdiv y
//  div_ovf    in   1        from fdiv ovf
//  busy       out  1        high in BUSY or DONE
//  ops_done   out  32       count of completed responses; wraps 0xFFFFFFFF->0
// BEHAVIOUR
//  Reset values (async, rstn low):
//  - state=IDLE; last_grant=NREQ-1, so requester 0 has first priority.
//  - op_x1/op_x2/res_y=0, res_ovf=0, owner=0, cnt=0, ops_done=0.
//  - Resulting outputs: req_ready=0, resp_valid=0, busy=0, div_x1=div_x2=0.
//  div_x1/div_x2 are driven directly from op_x1/op_x2 in every state.
//  IDLE:
//  - Grant goes to the first requester with req_valid high, searching last_grant+1, +2, ... modulo NREQ.
//  - req_ready is combinational: one-hot grant bit, only in IDLE, only if some req_valid is high.
//  - On the handshake edge: op_x1/op_x2 <= the granted slices; owner <= g; cnt <= DIV_CYCLES-1; ->BUSY.
//  - If no requester is valid, stay in IDLE; registers are unchanged.
//  BUSY:
//  - req_ready=0.
//  - If cnt!=0: cnt <= cnt-1.
//  - If cnt==0: res_y <= div_y; res_ovf <= div_ovf; ->DONE.
//  - Latency: resp_valid rises DIV_CYCLES edges after the request handshake edge.
//  DONE:
//  - resp_valid[owner]=1; resp_y=res_y; resp_ovf=res_ovf; all other resp_valid bits are 0.
//  - If resp_ready[owner] is high: last_grant <= owner; ops_done <= ops_done+1; ->IDLE.
//  - resp_ready of non-owners is ignored.
//  - Backpressure: the response stays stable and no grant is issued while resp_ready[owner] is low.
//  Boundary conditions:
//  - No grant in the same cycle as a response accept.
//    Sustained throughput is 1 op per DIV_CYCLES+2 cycles when resp_ready=1.
//  - Fairness: a requester that keeps req_valid high cannot be granted twice
//    while another requester is waiting.
//  - A request withdrawn before its handshake is simply not granted (no grant is latched).
//  - Reset mid-operation aborts the op: no response is issued, and the next grant restarts at requester 0.
//  - No X on any output after reset, including when req_x* are X but req_valid=0.
// TESTING
//  - Single op, NREQ=4, DIV_CYCLES=2: req0 x1=0x40400000, x2=0x40000000
//    -> req_ready=0001 for 1 cycle; resp_valid=0001 2 edges later; resp_y=0x3FC00000, resp_ovf=0; ops_done=1.
//  - All four req_valid high at reset release with resp_ready=1111
//    -> grants in order 0,1,2,3, one every 4 cycles; each resp_valid one-hot matches its grant.
//  - Overflow: x1=0x7F000000, x2=0x00800000 -> resp_y=0x7F800000, resp_ovf=1.
//  - Backpressure: hold resp_ready[owner]=0 for 5 cycles with req1 valid
//    -> resp_valid, resp_y and resp_ovf stable for 5 cycles, req_ready=0; req1 is granted on the cycle after accept.
//  - Fairness: req0 and req2 permanently valid -> grant sequence 0,2,0,2,...;
//    ops_done matches the number of handshakes.
//  - Reset pulse while in BUSY (cnt=1) -> no resp_valid afterwards; busy=0;
//    the first post-reset grant goes to requester 0 even if requester 3 was last.

Source files
------------

// File: rtl/fdiv_arbiter.sv
// Round-robin sharing of one external multicycle fdiv among NREQ issue ports.
// Operands are held on div_x1/div_x2 for DIV_CYCLES cycles, then the result is returned to the owner.
module fdiv_arbiter #(
    parameter int NREQ       = 4,
    parameter int DIV_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_x1,
    input  logic [32*NREQ-1:0]   req_x2,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          resp_y,
    output logic                 resp_ovf,
    output logic [31:0]          div_x1,
    output logic [31:0]          div_x2,
    input  logic [31:0]          div_y,
    input  logic                 div_ovf,
    output logic                 busy,
    output logic [31:0]          ops_done
);

    // state | meaning
    // IDLE  | searching for the next requester, req_ready one-hot
    // BUSY  | operands held on the fdiv inputs, counting down cnt
    // DONE  | result presented to the owner until resp_ready[owner]

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

    logic [1:0]      state_q,      state_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [GW-1:0]   owner_q,      owner_d;
    logic [CW-1:0]   cnt_q,        cnt_d;
    logic [31:0]     op_x1_q,      op_x1_d;
    logic [31:0]     op_x2_q,      op_x2_d;
    logic [31:0]     res_y_q,      res_y_d;
    logic            res_ovf_q,    res_ovf_d;
    logic [31:0]     ops_done_q,   ops_done_d;

    logic            grant_any;
    logic [GW-1:0]   grant_idx;
    logic [NREQ-1:0] grant_oh;
    logic [NREQ-1:0] owner_oh;

    // Search starts just after the last served requester, so it has lowest priority next.
    always_comb begin
        logic [GW-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_grant_q) + k) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant_oh            = '0;
        grant_oh[grant_idx] = 1'b1;
        owner_oh            = '0;
        owner_oh[owner_q]   = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        op_x1_d      = op_x1_q;
        op_x2_d      = op_x2_q;
        res_y_d      = res_y_q;
        res_ovf_d    = res_ovf_q;
        ops_done_d   = ops_done_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    op_x1_d = req_x1[32*grant_idx +: 32];
                    op_x2_d = req_x2[32*grant_idx +: 32];
                    owner_d = grant_idx;
                    cnt_d   = CNT_LOAD;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    res_y_d   = div_y;
                    res_ovf_d = div_ovf;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready[owner_q]) begin
                    last_grant_d = owner_q;
                    ops_done_d   = ops_done_q + 32'd1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            last_grant_q <= LAST_RST;
            owner_q      <= '0;
            cnt_q        <= '0;
            op_x1_q      <= '0;
            op_x2_q      <= '0;
            res_y_q      <= '0;
            res_ovf_q    <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            op_x1_q      <= op_x1_d;
            op_x2_q      <= op_x2_d;
            res_y_q      <= res_y_d;
            res_ovf_q    <= res_ovf_d;
            ops_done_q   <= ops_done_d;
        end
    end

    // No grant while busy or presenting a result, including the accept cycle.
    assign req_ready  = (state_q == S_IDLE && grant_any) ? grant_oh : '0;
    assign resp_valid = (state_q == S_DONE) ? owner_oh : '0;
    assign resp_y     = res_y_q;
    assign resp_ovf   = res_ovf_q;
    assign div_x1     = op_x1_q;
    assign div_x2     = op_x2_q;
    assign busy       = (state_q == S_BUSY) || (state_q == S_DONE);
    assign ops_done   = ops_done_q;

endmodule
